ipdc_disp_buffer: RTL
=====================

Name: ipdc_disp_buffer

Overview:
- Downstream stage of the image display controller. It captures each 4x4 display frame (16 pixels of 24-bit RGB/YCbCr) that the controller emits on its out_valid/out_data pair.
- Frames land in a ping-pong buffer, then scan out to the display/monitor interface over a valid/ready handshake, with row/column tags and a last-beat marker.
- The upstream controller has no output backpressure. This block therefore absorbs bursts and flags dropped or truncated frames instead of stalling.

Parameters:
- PIX_W, 24, pixel width in bits.
- FRAME_PIX, 16, pixels per display frame (4x4). Fixed geometry; row/col derive from it.
- GAP_TIMEOUT, 8, idle cycles allowed inside a frame before it is declared truncated.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_pix_valid  in  1  pixel strobe from the controller's out_valid.
- i_pix_data  in  PIX_W  pixel from the controller's out_data.
- o_disp_valid  out  1  display beat valid.
- o_disp_data  out  PIX_W  display pixel.
- o_disp_row  out  2  pixel row 0..3 (index>>2).
- o_disp_col  out  2  pixel column 0..3 (index&3).
- o_disp_last  out  1  high on index 15 beat.
- i_disp_ready  in  1  display sink ready.
- o_frame_drop  out  1  1-cycle pulse: a complete frame was discarded because no bank was free.
- o_frame_err  out  1  1-cycle pulse: partial frame discarded on gap timeout.
- o_busy  out  1  both banks full (status only).

Behaviour:
- Reset: i_rst_n is asynchronous, active-low; clock is i_clk.
  - All outputs go to 0; both banks are marked empty; writer is in W_IDLE, reader in R_IDLE.
  - Bank contents are not reset.
- Storage: two banks of FRAME_PIX x PIX_W. Each bank has a full flag (registered).
- Writer FSM, states W_IDLE, W_FILL, W_DROP:
  - W_IDLE + i_pix_valid:
    - If some bank is empty (flags as registered before this edge; no same-edge bypass), store the pixel at index 0 of the lowest-numbered empty bank, set wr_cnt=1, go to W_FILL.
    - Otherwise set wr_cnt=1 and go to W_DROP.
  - W_FILL/W_DROP + i_pix_valid: store (FILL only) at wr_cnt, then wr_cnt++ and clear the gap counter.
    - On the 16th pixel, FILL sets the bank full; DROP pulses o_frame_drop the next cycle. Both return to W_IDLE.
  - W_FILL/W_DROP without i_pix_valid: gap counter increments.
    - When it reaches GAP_TIMEOUT, discard the partial frame (bank stays empty), pulse o_frame_err, and go to W_IDLE.
- Reader FSM, states R_IDLE, R_SEND:
  - R_IDLE: when any bank is full, select the oldest full bank (a 1-bit order register records which bank filled first), set rd_cnt=0, go to R_SEND.
  - First o_disp_valid appears 1 cycle after the full flag is set, i.e. 2 edges after the 16th pixel is accepted.
  - R_SEND: outputs are registered. o_disp_data/row/col/last must stay stable while o_disp_valid && !i_disp_ready.
  - On handshake (valid && ready): rd_cnt++ and present the next pixel the next cycle, with no bubble.
  - On the last-beat handshake: clear that bank's full flag at the same edge, drop o_disp_valid for 1 cycle (R_IDLE), then start the next full bank if one exists.
- o_busy = both full flags set.
- Simultaneous events:
  - A bank freed at edge N is visible to the writer only at edge N+1.
  - A frame start coinciding with the free event is dropped.
- Reset mid-frame on either side aborts immediately; no pulses are generated.
- i_pix_data is don't-care when i_pix_valid=0.

Optional Feature:
- Macro: IPDC_DISP_REPEAT_EN.
- Defined:
  - After the last beat, if no other bank is full, the reader keeps the displayed bank (full flag stays set) and rescans it from index 0 after the 1-cycle gap, for continuous display refresh.
  - The held bank is released at the last-beat handshake of the first pass completed after the other bank becomes full; the reader then switches to the other bank.
  - While a bank is held, the writer has only the other bank available.
- Undefined: the reader frees the bank after one pass and idles in R_IDLE.

Test Plan:
- Single frame: 16 consecutive pixels 0x000000..0x00000F, ready=1 -> 16 beats, data 0x00..0x0F, row/col (0,0)..(3,3), last only on 0x0F, first beat 2 edges after 16th input.
- Backpressure: ready toggles 1,0,0,1 repeating -> data/row/col hold across stalls; all 16 values delivered in order, no duplicates.
- Overflow: ready=0, send 3 frames (A=0x1xxxxx, B=0x2xxxxx, C=0x3xxxxx) -> o_busy=1 after B, one o_frame_drop pulse after C's 16th pixel; ready=1 then yields A then B.
- Gap timeout: 5 pixels, then 8 idle cycles -> one o_frame_err pulse, no display output; a following full frame displays normally from index 0.
- Reset mid-scan: assert i_rst_n=0 at beat 7 -> o_disp_valid=0 immediately, no pulses; the next frame after release displays starting at row 0, col 0.
- IPDC_DISP_REPEAT_EN: one frame, ready=1 for 40 cycles -> frame repeated with a 1-cycle gap between passes; sending a second frame switches output after the current pass's last beat.

Source files
------------

// File: rtl/ipdc_disp_buffer.sv
// ============================================================================
// Module   : ipdc_disp_buffer
// Captures 4x4 display frames into a ping-pong buffer and scans them out over
// valid/ready. Optional macro IPDC_DISP_REPEAT_EN: rescan the held bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ipdc_disp_buffer #(
  parameter int PIX_W       = 24,
  parameter int FRAME_PIX   = 16,
  parameter int GAP_TIMEOUT = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pix_valid,
  input  logic [PIX_W-1:0] i_pix_data,
  output logic             o_disp_valid,
  output logic [PIX_W-1:0] o_disp_data,
  output logic [1:0]       o_disp_row,
  output logic [1:0]       o_disp_col,
  output logic             o_disp_last,
  input  logic             i_disp_ready,
  output logic             o_frame_drop,
  output logic             o_frame_err,
  output logic             o_busy
);

  localparam int c_IDX_W = $clog2(FRAME_PIX);
  localparam int c_GAP_W = $clog2(GAP_TIMEOUT + 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(FRAME_PIX - 1);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_DROP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_SEND = 1'b1
  } rd_state_t;

  logic [PIX_W-1:0] r_mem [0:1][0:FRAME_PIX-1];

  wr_state_t        r_wr_state, w_wr_state_nxt;
  logic             r_wr_bank, w_wr_bank_nxt;
  logic [c_IDX_W-1:0] r_wr_cnt, w_wr_cnt_nxt;
  logic [c_GAP_W-1:0] r_gap_cnt, w_gap_nxt;
  logic             w_we;
  logic             w_we_bank;
  logic [c_IDX_W-1:0] w_we_idx;
  logic             w_set;
  logic             w_drop;
  logic             w_err;
  logic             w_free_bank;

  rd_state_t        r_rd_state, w_rd_state_nxt;
  logic             r_rd_bank, w_rd_bank_nxt;
  logic [c_IDX_W-1:0] r_rd_cnt, w_rd_cnt_nxt;
  logic             w_valid_nxt;
  logic             w_load;
  logic [c_IDX_W-1:0] w_ld_idx;
  logic             w_clr;
  logic             w_sel_bank;

  logic [1:0]       r_full, w_full_nxt;
  logic             r_order, w_order_nxt;

  logic             r_disp_valid;
  logic [PIX_W-1:0] r_disp_data;
  logic [1:0]       r_disp_row;
  logic [1:0]       r_disp_col;
  logic             r_disp_last;
  logic             r_frame_drop;
  logic             r_frame_err;

  assign w_free_bank = r_full[0] ? 1'b1 : 1'b0;
  // With both banks full the order register names the older one.
  assign w_sel_bank  = (&r_full) ? r_order : ~r_full[0];

  // ---------------------------------------------------------------- writer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_state <= W_IDLE;
      r_wr_bank  <= 1'b0;
      r_wr_cnt   <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_wr_bank  <= w_wr_bank_nxt;
      r_wr_cnt   <= w_wr_cnt_nxt;
      r_gap_cnt  <= w_gap_nxt;
    end
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_bank_nxt  = r_wr_bank;
    w_wr_cnt_nxt   = r_wr_cnt;
    w_gap_nxt      = r_gap_cnt;
    w_we           = 1'b0;
    w_we_bank      = r_wr_bank;
    w_we_idx       = r_wr_cnt;
    w_set          = 1'b0;
    w_drop         = 1'b0;
    w_err          = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        if (i_pix_valid) begin
          w_wr_cnt_nxt = c_IDX_W'(1);
          w_gap_nxt    = '0;
          if (!(&r_full)) begin
            w_we           = 1'b1;
            w_we_bank      = w_free_bank;
            w_we_idx       = '0;
            w_wr_bank_nxt  = w_free_bank;
            w_wr_state_nxt = W_FILL;
          end else begin
            w_wr_state_nxt = W_DROP;
          end
        end
      end
      W_FILL, W_DROP: begin
        if (i_pix_valid) begin
          w_we      = (r_wr_state == W_FILL);
          w_gap_nxt = '0;
          if (r_wr_cnt == c_IDX_LAST) begin
            w_set          = (r_wr_state == W_FILL);
            w_drop         = (r_wr_state == W_DROP);
            w_wr_cnt_nxt   = '0;
            w_wr_state_nxt = W_IDLE;
          end else begin
            w_wr_cnt_nxt = r_wr_cnt + 1'b1;
          end
        end else if (r_gap_cnt == c_GAP_LAST) begin
          w_err          = 1'b1;
          w_gap_nxt      = '0;
          w_wr_cnt_nxt   = '0;
          w_wr_state_nxt = W_IDLE;
        end else begin
          w_gap_nxt = r_gap_cnt + 1'b1;
        end
      end
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[w_we_bank][w_we_idx] <= i_pix_data;
  end

  // ------------------------------------------------------ bank bookkeeping
  always_comb begin
    w_full_nxt  = r_full;
    w_order_nxt = r_order;
    if (w_clr) begin
      w_full_nxt[r_rd_bank] = 1'b0;
      w_order_nxt           = ~r_rd_bank;
    end
    if (w_set) begin
      w_full_nxt[r_wr_bank] = 1'b1;
      // Newly filled bank is the oldest unless the other one stays full.
      if (!r_full[~r_wr_bank] || (w_clr && (r_rd_bank != r_wr_bank)))
        w_order_nxt = r_wr_bank;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full       <= 2'b00;
      r_order      <= 1'b0;
      r_frame_drop <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_full       <= w_full_nxt;
      r_order      <= w_order_nxt;
      r_frame_drop <= w_drop;
      r_frame_err  <= w_err;
    end
  end

  // ---------------------------------------------------------------- reader
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_bank_nxt  = r_rd_bank;
    w_rd_cnt_nxt   = r_rd_cnt;
    w_valid_nxt    = r_disp_valid;
    w_load         = 1'b0;
    w_ld_idx       = r_rd_cnt;
    w_clr          = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        if (|r_full) begin
          w_rd_bank_nxt  = w_sel_bank;
          w_rd_cnt_nxt   = '0;
          w_ld_idx       = '0;
          w_load         = 1'b1;
          w_valid_nxt    = 1'b1;
          w_rd_state_nxt = R_SEND;
        end
      end
      R_SEND: begin
        if (r_disp_valid && i_disp_ready) begin
          if (r_rd_cnt == c_IDX_LAST) begin
`ifdef IPDC_DISP_REPEAT_EN
            w_clr = r_full[~r_rd_bank];
`else
            w_clr = 1'b1;
`endif
            w_valid_nxt    = 1'b0;
            w_rd_state_nxt = R_IDLE;
          end else begin
            w_rd_cnt_nxt = r_rd_cnt + 1'b1;
            w_ld_idx     = r_rd_cnt + 1'b1;
            w_load       = 1'b1;
          end
        end
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_state   <= R_IDLE;
      r_rd_bank    <= 1'b0;
      r_rd_cnt     <= '0;
      r_disp_valid <= 1'b0;
      r_disp_data  <= '0;
      r_disp_row   <= 2'd0;
      r_disp_col   <= 2'd0;
      r_disp_last  <= 1'b0;
    end else begin
      r_rd_state   <= w_rd_state_nxt;
      r_rd_bank    <= w_rd_bank_nxt;
      r_rd_cnt     <= w_rd_cnt_nxt;
      r_disp_valid <= w_valid_nxt;
      if (w_load) begin
        r_disp_data <= r_mem[w_rd_bank_nxt][w_ld_idx];
        r_disp_row  <= w_ld_idx[3:2];
        r_disp_col  <= w_ld_idx[1:0];
        r_disp_last <= (w_ld_idx == c_IDX_LAST);
      end else if (!w_valid_nxt) begin
        r_disp_last <= 1'b0;
      end
    end
  end

  assign o_disp_valid = r_disp_valid;
  assign o_disp_data  = r_disp_data;
  assign o_disp_row   = r_disp_row;
  assign o_disp_col   = r_disp_col;
  assign o_disp_last  = r_disp_last;
  assign o_frame_drop = r_frame_drop;
  assign o_frame_err  = r_frame_err;
  assign o_busy       = &r_full;

endmodule

`default_nettype wire
